// File: rtl/ysyx_25020047_exu_iter.sv
// ysyx_25020047_exu_iter: multi-cycle execute unit, single-cycle base ops plus iterative RV32M multiply/divide
module ysyx_25020047_exu_iter #(
   parameter int XLEN = 32,
   parameter int OP_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   input  logic            use_imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] next_pc,
   output logic            reg_wen,
   output logic            mem_read,
   output logic            mem_write,
   output logic            ebreak,
   output logic            illegal
);
   localparam int SW = $clog2(XLEN);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [2*XLEN-1:0] p, p_nx, prod;
   logic [XLEN-1:0] b, half, dres, fin;
   logic [2:0] mop;
   logic neg;
   logic [31:0] opc;
   logic [XLEN-1:0] bo, pc4, pci, ea, am, bm, f_res, f_npc;
   logic m_op, is_div, a_sgn, b_sgn, div_z, div_ovf, iter, acc;
   logic lt, ltu, br, taken, f_wen, f_il;
   logic [XLEN:0] m_sum, d_rs, d_diff;
   assign opc = 32'(op);
   assign acc = in_valid & in_ready;
   assign in_ready = (state == IDLE) | (state == DONE & out_ready);
   assign out_valid = state == DONE;
   assign bo = (use_imm && opc <= 9) ? imm : src2;
   assign pc4 = pc + XLEN'(4);
   assign pci = pc + imm;
   assign ea = src1 + imm;
   assign lt = $signed(src1) < $signed(bo);
   assign ltu = src1 < bo;
   assign br = opc >= 14 && opc <= 19;
   assign taken = opc[0] ^ ((opc == 14 || opc == 15) ? src1 == src2 : opc[1] ? ltu : lt);
   assign f_npc = opc == 12 ? pci : opc == 13 ? ea & ~XLEN'(1) : (br && taken) ? pci : pc4;
   assign f_wen = opc <= 13 || opc == 20 || m_op;
   assign f_il = opc == 23 || opc > 31;
   // Signed M ops iterate on magnitudes; neg records how to fix the sign at the end
   assign m_op = opc >= 24 && opc <= 31;
   assign is_div = m_op & opc[2];
   assign a_sgn = m_op & (opc[2:0] == 3'd1 | opc[2:0] == 3'd2 | opc[2:0] == 3'd4 | opc[2:0] == 3'd6) & src1[XLEN-1];
   assign b_sgn = m_op & (opc[2:0] == 3'd1 | opc[2:0] == 3'd4 | opc[2:0] == 3'd6) & src2[XLEN-1];
   assign am = a_sgn ? -src1 : src1;
   assign bm = b_sgn ? -src2 : src2;
   assign div_z = is_div & (src2 == '0);
   assign div_ovf = is_div & !opc[0] & (src1 == MIN) & (&src2);
   assign iter = m_op & !div_z & !div_ovf;
   always_comb begin
      f_res = '0;
      case (opc)
         0: f_res = src1 + bo;
         1: f_res = src1 - bo;
         2: f_res = XLEN'(lt);
         3: f_res = XLEN'(ltu);
         4: f_res = src1 ^ bo;
         5: f_res = src1 | bo;
         6: f_res = src1 & bo;
         7: f_res = src1 << bo[SW-1:0];
         8: f_res = src1 >> bo[SW-1:0];
         9: f_res = $signed(src1) >>> bo[SW-1:0];
         10: f_res = imm;
         11: f_res = pci;
         12, 13: f_res = pc4;
         20, 21: f_res = ea;
         24, 25, 26, 27, 28, 29, 30, 31: f_res = div_z ? (opc[1] ? src1 : '1) : div_ovf ? (opc[1] ? '0 : MIN) : '0;
         default: f_res = '0;
      endcase
   end
   // p holds {acc, multiplier} for multiply and {remainder, quotient} for divide
   assign m_sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, b} : '0);
   assign d_rs = {p[2*XLEN-1:XLEN], p[XLEN-1]};
   assign d_diff = d_rs - {1'b0, b};
   assign p_nx = mop[2] ? {(d_diff[XLEN] ? d_rs[XLEN-1:0] : d_diff[XLEN-1:0]), p[XLEN-2:0], !d_diff[XLEN]} : {m_sum, p[XLEN-1:1]};
   assign prod = neg ? -p_nx : p_nx;
   assign half = mop[1] ? p_nx[2*XLEN-1:XLEN] : p_nx[XLEN-1:0];
   assign dres = neg ? -half : half;
   assign fin = mop[2] ? dres : mop[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   always_comb begin
      state_nx = state;
      if (acc) state_nx = iter ? BUSY : DONE;
      else if (state == BUSY) state_nx = cnt == CW'(1) ? DONE : BUSY;
      else if (state == DONE && out_ready) state_nx = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         p <= '0;
         b <= '0;
         mop <= '0;
         neg <= 1'b0;
         result <= '0;
         next_pc <= '0;
         reg_wen <= 1'b0;
         mem_read <= 1'b0;
         mem_write <= 1'b0;
         ebreak <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state <= state_nx;
         if (acc) begin
            cnt <= iter ? CW'(XLEN) : '0;
            p <= {{XLEN{1'b0}}, am};
            b <= bm;
            mop <= opc[2:0];
            neg <= opc[2:1] == 2'b11 ? a_sgn : a_sgn ^ b_sgn;
            result <= f_res;
            next_pc <= f_npc;
            reg_wen <= f_wen;
            mem_read <= opc == 20;
            mem_write <= opc == 21;
            ebreak <= opc == 22;
            illegal <= f_il;
         end else if (state == BUSY) begin
            p <= p_nx;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) result <= fin;
         end
      end
   end
endmodule

// File: tb/tb_ysyx_25020047_exu_iter.sv
// tb_ysyx_25020047_exu_iter: directed vectors checked by a per-cycle scoreboard and hand-computed literals
module tb_ysyx_25020047_exu_iter;
   logic clk = 0, rst = 1, in_valid = 0, use_imm = 0, out_ready = 1;
   logic in_ready, out_valid, reg_wen, mem_read, mem_write, ebreak, illegal;
   logic [4:0] op = 0;
   logic [31:0] src1 = 0, src2 = 0, imm = 0, pc = 0, result, next_pc;
   int n_chk = 0, n_fail = 0, n_out = 0, n_sent = 0;
   typedef struct packed { logic [31:0] res; logic [31:0] npc; logic [4:0] fl; } exp_t;
   exp_t q[$];
   typedef struct { int o; logic [31:0] a; logic [31:0] b; logic [31:0] im; logic [31:0] p; bit ui; int lat; } vec_t;
   vec_t tbl [28] = '{
      '{1, 32'd10, 32'd3, 0, 32'h200, 0, 1},
      '{2, 32'hFFFFFFFE, 32'd1, 0, 0, 0, 1},
      '{3, 32'hFFFFFFFE, 32'd1, 0, 0, 0, 1},
      '{4, 32'hF0F0, 0, 32'h0FF0, 0, 1, 1},
      '{5, 32'h1200, 32'h34, 0, 0, 0, 1},
      '{6, 32'hFF00FF, 32'h0F0F0F, 0, 0, 0, 1},
      '{7, 32'd1, 0, 32'h25, 0, 1, 1},
      '{8, 32'h80000000, 32'h1F, 0, 0, 0, 1},
      '{9, 32'h80000000, 32'h4, 0, 0, 0, 1},
      '{10, 0, 0, 32'h12345000, 0, 0, 1},
      '{11, 0, 0, 32'h1000, 32'h80000000, 0, 1},
      '{12, 0, 0, 32'hFFFFFFF8, 32'h80000010, 0, 1},
      '{13, 32'h80000101, 0, 32'h4, 32'h80000020, 0, 1},
      '{14, 32'd5, 32'd5, 32'h20, 32'h100, 0, 1},
      '{15, 32'd5, 32'd5, 32'h20, 32'h100, 0, 1},
      '{17, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 0, 1},
      '{19, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 0, 1},
      '{20, 32'h1000, 0, 32'hFFFFFFFC, 0, 0, 1},
      '{21, 32'h1000, 0, 32'd8, 0, 0, 1},
      '{22, 0, 0, 0, 32'h40, 0, 1},
      '{24, 32'hFFFFFFFD, 32'd7, 0, 0, 0, 33},
      '{26, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 33},
      '{29, 32'd100, 32'd7, 0, 0, 0, 33},
      '{31, 32'd100, 32'd7, 0, 0, 0, 33},
      '{29, 32'd100, 0, 0, 0, 0, 1},
      '{31, 32'd100, 0, 0, 0, 0, 1},
      '{28, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 1},
      '{29, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 33}
   };

   ysyx_25020047_exu_iter #(.XLEN(32), .OP_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .src1(src1), .src2(src2), .imm(imm), .pc(pc), .use_imm(use_imm),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .next_pc(next_pc),
      .reg_wen(reg_wen), .mem_read(mem_read), .mem_write(mem_write), .ebreak(ebreak), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic exp_t model(int o, logic [31:0] a, logic [31:0] b, logic [31:0] im, logic [31:0] p, bit ui);
      exp_t e;
      logic [31:0] bb;
      logic signed [63:0] ss;
      logic [63:0] uu;
      bit tk;
      bb = (ui && o <= 9) ? im : b;
      e.res = 0;
      e.npc = p + 4;
      e.fl = {(o <= 13 || o == 20 || (o >= 24 && o <= 31)), o == 20, o == 21, o == 22, (o == 23 || o > 31)};
      case (o)
         0: e.res = a + bb;
         1: e.res = a - bb;
         2: e.res = {31'b0, $signed(a) < $signed(bb)};
         3: e.res = {31'b0, a < bb};
         4: e.res = a ^ bb;
         5: e.res = a | bb;
         6: e.res = a & bb;
         7: e.res = a << bb[4:0];
         8: e.res = a >> bb[4:0];
         9: e.res = $signed(a) >>> bb[4:0];
         10: e.res = im;
         11: e.res = p + im;
         12: begin e.res = p + 4; e.npc = p + im; end
         13: begin e.res = p + 4; e.npc = (a + im) & 32'hFFFFFFFE; end
         14, 15, 16, 17, 18, 19: begin
            tk = o == 14 ? a == b : o == 15 ? a != b : o == 16 ? $signed(a) < $signed(b) :
                 o == 17 ? $signed(a) >= $signed(b) : o == 18 ? a < b : a >= b;
            e.npc = tk ? p + im : p + 4;
         end
         20, 21: e.res = a + im;
         24: begin uu = {32'b0, a} * {32'b0, b}; e.res = uu[31:0]; end
         25: begin ss = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); e.res = ss[63:32]; end
         26: begin ss = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); e.res = ss[63:32]; end
         27: begin uu = {32'b0, a} * {32'b0, b}; e.res = uu[63:32]; end
         28: if (b == 0) e.res = '1; else if (a == 32'h80000000 && b == '1) e.res = a; else e.res = $signed(a) / $signed(b);
         29: if (b == 0) e.res = '1; else e.res = a / b;
         30: if (b == 0) e.res = a; else if (a == 32'h80000000 && b == '1) e.res = 0; else e.res = $signed(a) % $signed(b);
         31: if (b == 0) e.res = a; else e.res = a % b;
         default: e.res = 0;
      endcase
      return e;
   endfunction

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst) q.delete();
         else begin
            if (out_valid) begin
               if (q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
               else chk("scoreboard", {result, next_pc, reg_wen, mem_read, mem_write, ebreak, illegal}, q[0]);
               if (out_ready && q.size() > 0) begin
                  void'(q.pop_front());
                  n_out++;
               end
            end
            if (in_valid && in_ready) q.push_back(model(int'(op), src1, src2, imm, pc, use_imm));
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input logic [31:0] p, input bit ui);
      int k = 0;
      op = 5'(o); src1 = a; src2 = b; imm = im; pc = p; use_imm = ui; in_valid = 1;
      @(negedge clk);
      while (!in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("send_accept", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 0;
      src1 = $urandom; src2 = $urandom; imm = $urandom; pc = $urandom; op = 5'($urandom); use_imm = 1;
      n_sent++;
   endtask

   task automatic run(input int o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                      input bit ui, input int lat, input string nm, output int busy);
      int k = 1;
      send(o, a, b, im, p, ui);
      busy = 0;
      @(negedge clk);
      while (!out_valid && k < 100) begin
         if (!in_ready) busy++;
         @(negedge clk);
         k++;
      end
      chk({nm, "_latency"}, k, lat);
   endtask

   initial begin
      int busy, base;
      fork
         monitor();
      join_none
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_outputs", {result, next_pc, reg_wen, mem_read, mem_write, ebreak, illegal}, 0);
      step();
      run(0, 5, 32'hFFFFFFFF, 0, 32'h100, 0, 1, "add", busy);
      chk("add_result", result, 4);
      chk("add_reg_wen", reg_wen, 1);
      chk("add_next_pc", next_pc, 32'h104);
      step();
      @(negedge clk);
      chk("valid_drops_after_handshake", out_valid, 0);
      step();
      run(16, 32'hFFFFFFFF, 1, 32'h10, 32'h80000000, 0, 1, "blt", busy);
      chk("blt_next_pc", next_pc, 32'h80000010);
      chk("blt_reg_wen", reg_wen, 0);
      step();
      run(18, 32'hFFFFFFFF, 1, 32'h10, 32'h80000000, 0, 1, "bltu", busy);
      chk("bltu_next_pc", next_pc, 32'h80000004);
      step();
      run(25, 32'h80000000, 32'h80000000, 0, 0, 0, 33, "mulh", busy);
      chk("mulh_busy_cycles", busy, 32);
      chk("mulh_result", result, 32'h40000000);
      step();
      run(27, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 33, "mulhu", busy);
      chk("mulhu_result", result, 32'hFFFFFFFE);
      step();
      run(28, 7, 0, 0, 0, 0, 1, "div_by_zero", busy);
      chk("div_by_zero_result", result, 32'hFFFFFFFF);
      step();
      run(30, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 1, "rem_overflow", busy);
      chk("rem_overflow_result", result, 0);
      step();
      run(28, 32'hFFFFFFF9, 2, 0, 0, 0, 33, "div_neg", busy);
      chk("div_neg_result", result, 32'hFFFFFFFD);
      step();
      run(30, 32'hFFFFFFF9, 2, 0, 0, 0, 33, "rem_neg", busy);
      chk("rem_neg_result", result, 32'hFFFFFFFF);
      step();
      foreach (tbl[i]) begin
         run(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].im, tbl[i].p, tbl[i].ui, tbl[i].lat, $sformatf("tbl%0d", i), busy);
         step();
      end
      base = n_out;
      fork
         for (int i = 0; i < 4; i++) send(0, 32'(i + 1), 32'(i + 1), 0, 32'h300 + 32'(4 * i), 0);
         begin
            int k = 0;
            @(negedge clk);
            while (!out_valid && k < 20) begin
               @(negedge clk);
               k++;
            end
            @(posedge clk);
            #1 out_ready = 0;
            repeat (3) begin
               @(negedge clk);
               chk("stall_result", result, 4);
               chk("stall_in_ready", in_ready, 0);
            end
            @(posedge clk);
            #1 out_ready = 1;
         end
      join
      repeat (3) @(negedge clk);
      chk("stream_count", n_out - base, 4);
      step();
      send(29, 32'h1234567, 3, 0, 0, 0);
      repeat (9) @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_busy_out_valid", out_valid, 0);
      chk("rst_busy_in_ready", in_ready, 1);
      step();
      run(23, 1, 2, 3, 32'h500, 0, 1, "illegal", busy);
      chk("illegal_flag", illegal, 1);
      chk("illegal_reg_wen", reg_wen, 0);
      chk("illegal_result", result, 0);
      step();
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      chk("result_count", n_out, n_sent - 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
